// File: rtl/hs_elastic_fifo.sv
// Valid/ready elastic buffer: DEPTH-entry first-word-fall-through FIFO.
// Handshake outputs derive only from registered occupancy, so no input-to-output combinational paths exist.
module hs_elastic_fifo #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [WIDTH-1:0]             out,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    always_comb begin
        ready_o     = (count != DEPTH_C);
        valid_o     = (count != '0);
        almost_full = (count >= AFULL_C);
        out         = mem[rd_ptr];
        push        = valid_i & ready_o;
        pop         = valid_o & ready_i;
    end

    // Storage is never reset; a beat offered during flush or reset is simply not written.
    always_ff @(posedge clk_core) begin
        if (push && !flush && !rst_core)
            mem[wr_ptr] <= in;
    end

    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed and random bench for hs_elastic_fifo (DEPTH=4, WIDTH=8, AFULL_LEVEL=3)
// against a queue scoreboard that tracks accepted beats and expected handshake state.
module tb_hs_elastic_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic       clk_core = 1'b0;
    logic       rst_core = 1'b1;
    logic       flush    = 1'b0;
    logic [7:0] din      = '0;
    logic       valid_i  = 1'b0;
    logic       ready_i  = 1'b0;
    logic       ready_o;
    logic [7:0] dout;
    logic       valid_o;
    logic [2:0] count;
    logic       almost_full;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] sb [$];

    hs_elastic_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush       (flush),
        .in          (din),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .out         (dout),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; compares outputs, then advances the model across one rising edge.
    task automatic cycle();
        bit         push_m;
        bit         pop_m;
        logic [7:0] d;
        chk("count", 32'(count), 32'(sb.size()));
        chk("ready_o", 32'(ready_o), 32'(sb.size() != DEPTH));
        chk("valid_o", 32'(valid_o), 32'(sb.size() != 0));
        chk("almost_full", 32'(almost_full), 32'(sb.size() >= AFULL));
        if (sb.size() != 0)
            chk("out", 32'(dout), 32'(sb[0]));
        push_m = valid_i && (sb.size() != DEPTH);
        pop_m  = ready_i && (sb.size() != 0);
        d      = din;
        @(posedge clk_core);
        if (rst_core || flush) begin
            sb.delete();
        end else begin
            if (pop_m)
                void'(sb.pop_front());
            if (push_m)
                sb.push_back(d);
        end
        @(negedge clk_core);
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        valid_i = v;
        din     = d;
        ready_i = r;
        cycle();
    endtask

    initial begin
        // Initial reset: outputs are unknown before the first edge, so no checks here.
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        rst_core = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        drive(0, 8'h00, 0);

        // Fill to full with downstream stalled, then hold a fifth beat.
        for (int i = 1; i <= 4; i++)
            drive(1, 8'(i), 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready_o", 32'(ready_o), 32'd0);
        drive(1, 8'h05, 0);
        drive(1, 8'h05, 0);
        // Release: first cycle pops only, second accepts 0x05 while popping.
        drive(1, 8'h05, 1);
        chk("full_pop_count", 32'(count), 32'd3);
        chk("full_pop_ready_o", 32'(ready_o), 32'd1);
        drive(1, 8'h05, 1);
        for (int i = 0; i < 5; i++)
            drive(0, 8'hEE, 1);
        chk("drained_count", 32'(count), 32'd0);

        // Simultaneous valid/ready at full.
        for (int i = 0; i < 4; i++)
            drive(1, 8'(8'h30 + i), 0);
        drive(1, 8'h20, 1);
        chk("simul_full_count", 32'(count), 32'd3);
        drive(1, 8'h20, 1);
        for (int i = 0; i < 5; i++)
            drive(0, 8'h00, 1);

        // Reset mid-traffic at count 3, with a beat offered during reset.
        for (int i = 0; i < 3; i++)
            drive(1, 8'(8'h40 + i), 0);
        rst_core = 1'b1;
        drive(1, 8'h77, 0);
        drive(1, 8'h77, 0);
        rst_core = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        drive(1, 8'hA5, 0);
        chk("a5_head", 32'(dout), 32'hA5);
        drive(0, 8'h00, 1);

        // Flush together with a push; only the next beat survives.
        drive(1, 8'h10, 0);
        drive(1, 8'h11, 0);
        flush = 1'b1;
        drive(1, 8'h12, 0);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid_o", 32'(valid_o), 32'd0);
        drive(1, 8'h13, 1);
        chk("flush_head", 32'(dout), 32'h13);
        drive(0, 8'h00, 1);
        chk("flush_drained", 32'(count), 32'd0);

        // Streaming: one beat per cycle, occupancy settles at 1.
        for (int i = 0; i < 64; i++)
            drive(1, 8'(i), 1);
        chk("stream_count", 32'(count), 32'd1);
        drive(0, 8'h00, 1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            flush = ($urandom_range(0, 63) == 0);
            drive(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));
        end
        flush = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(0, 8'h00, 1);
        chk("final_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
